// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for in-order issue.
// Tracks pending writes and stalls decode on RAW/WAW/structural hazards.
module hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int REG_BITS  = 5,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic [REG_BITS-1:0] dec_rs1,
  input  logic [REG_BITS-1:0] dec_rs2,
  input  logic [REG_BITS-1:0] dec_rd,
  input  logic                dec_use_rs1,
  input  logic                dec_use_rs2,
  input  logic                dec_wr_rd,
  input  logic                dec_kill,
  input  logic                ext_stall,
  input  logic                wb_valid,
  input  logic [REG_BITS-1:0] wb_rd,
  output logic                stall_decode,
  output logic [1:0]          stall_reason,
  output logic [REG_BITS:0]   outstanding,
  output logic [15:0]         stall_cycles,
  output logic                sb_err
);

  localparam int CW = REG_BITS + 1;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [15:0]      stall_cycles_q, stall_cycles_d;
  logic             sb_err_q, sb_err_d;

  logic rs1_busy, rs2_busy;
  logic raw, waw, stall, issue;

  // Hazard detection and decode stall, purely combinational
  always_comb begin
    rs1_busy = busy_q[dec_rs1]
             & ~(BYPASS_WB & wb_valid & (wb_rd == dec_rs1));
    rs2_busy = busy_q[dec_rs2]
             & ~(BYPASS_WB & wb_valid & (wb_rd == dec_rs2));
    raw = dec_valid
        & ((dec_use_rs1 & rs1_busy) | (dec_use_rs2 & rs2_busy));
    waw = dec_valid & dec_wr_rd & busy_q[dec_rd]
        & (dec_rd != '0);
    stall = ~dec_kill & (ext_stall | raw | waw);
    issue = dec_valid & ~dec_kill & ~stall;
    stall_reason = 2'd0;
    if (stall) begin
      if (ext_stall)  stall_reason = 2'd1;
      else if (raw)   stall_reason = 2'd2;
      else            stall_reason = 2'd3;
    end
  end

  // Next-state: wb clears first so a same-index issue set wins
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_rd != '0))
      busy_d[wb_rd] = 1'b0;
    if (issue && dec_wr_rd && (dec_rd != '0))
      busy_d[dec_rd] = 1'b1;
    busy_d[0] = 1'b0;

    outstanding_d = '0;
    for (int i = 0; i < NREGS; i++)
      outstanding_d = outstanding_d + CW'(busy_d[i]);

    sb_err_d = sb_err_q
             | (wb_valid & (wb_rd != '0) & ~busy_q[wb_rd]);

    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF))
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q         <= '0;
      outstanding_q  <= '0;
      stall_cycles_q <= '0;
      sb_err_q       <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      outstanding_q  <= outstanding_d;
      stall_cycles_q <= stall_cycles_d;
      sb_err_q       <= sb_err_d;
    end
  end

  assign stall_decode = stall;
  assign outstanding  = outstanding_q;
  assign stall_cycles = stall_cycles_q;
  assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vectors plus
// a per-cycle reference model of the busy-register set.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_use_rs1, dec_use_rs2, dec_wr_rd;
  logic       dec_kill, ext_stall;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       stall_decode;
  logic [1:0] stall_reason;
  logic [5:0] outstanding;
  logic [15:0] stall_cycles;
  logic       sb_err;

  int n_total = 0;
  int n_bad   = 0;

  hazard_scoreboard #(
    .NREGS(32), .REG_BITS(5), .BYPASS_WB(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_wr_rd(dec_wr_rd),
    .dec_kill(dec_kill), .ext_stall(ext_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall_decode(stall_decode), .stall_reason(stall_reason),
    .outstanding(outstanding), .stall_cycles(stall_cycles),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_busy [32];
  int m_sc;
  bit m_err;
  bit m_init = 0;

  function automatic bit pending(input int r);
    if (r == 0 || !m_busy[r]) return 0;
    if (wb_valid && int'(wb_rd) == r) return 0;
    return 1;
  endfunction

  always @(negedge clk) begin
    bit e_raw, e_waw, e_stall, e_issue;
    int e_reason, cnt;
    e_raw = dec_valid &&
      ((dec_use_rs1 && pending(int'(dec_rs1))) ||
       (dec_use_rs2 && pending(int'(dec_rs2))));
    e_waw = dec_valid && dec_wr_rd && dec_rd != 0
            && m_busy[dec_rd];
    e_stall = !dec_kill && (ext_stall || e_raw || e_waw);
    e_reason = !e_stall ? 0 : ext_stall ? 1 : e_raw ? 2 : 3;
    cnt = 0;
    foreach (m_busy[i]) cnt += m_busy[i];
    if (m_init) begin
      chk("m_stall", 32'(stall_decode), 32'(e_stall));
      chk("m_reason", 32'(stall_reason), 32'(e_reason));
      chk("m_outstanding", 32'(outstanding), 32'(cnt));
      chk("m_stall_cycles", 32'(stall_cycles), 32'(m_sc));
      chk("m_sb_err", 32'(sb_err), 32'(m_err));
    end
    e_issue = dec_valid && !dec_kill && !e_stall;
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_sc = 0;
      m_err = 0;
      m_init = 1;
    end else begin
      if (wb_valid && wb_rd != 0) begin
        if (!m_busy[wb_rd]) m_err = 1;
        m_busy[wb_rd] = 0;
      end
      if (e_issue && dec_wr_rd && dec_rd != 0)
        m_busy[dec_rd] = 1;
      if (e_stall && m_sc < 65535) m_sc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; dec_wr_rd = 0;
    dec_kill = 0; ext_stall = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r);
    idle();
    dec_valid = 1; dec_wr_rd = 1; dec_rd = r;
  endtask

  task automatic rd1(input logic [4:0] r);
    idle();
    dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = r;
  endtask

  task automatic ret(input logic [4:0] r);
    wb_valid = 1; wb_rd = r;
  endtask

  initial begin
    idle();
    reset = 1;
    nxt(); nxt();
    mid();
    chk("rst_stall", 32'(stall_decode), 0);
    chk("rst_reason", 32'(stall_reason), 0);
    nxt();
    reset = 0;
    mid();
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_sc", 32'(stall_cycles), 0);
    chk("rst_err", 32'(sb_err), 0);
    nxt();

    // RAW with same-cycle writeback bypass
    wr(5); mid(); chk("raw_issue", 32'(stall_decode), 0); nxt();
    rd1(5); mid();
    chk("raw_stall", 32'(stall_decode), 1);
    chk("raw_reason", 32'(stall_reason), 2);
    chk("raw_out", 32'(outstanding), 1);
    nxt();
    ret(5); mid(); chk("raw_bypass", 32'(stall_decode), 0); nxt();
    idle(); mid();
    chk("raw_cleared", 32'(outstanding), 0);
    chk("raw_sc", 32'(stall_cycles), 1);
    nxt();

    // WAW held until the older write retires
    wr(7); mid(); nxt();
    repeat (3) begin
      mid(); chk("waw_reason", 32'(stall_reason), 3); nxt();
    end
    ret(7); mid();
    chk("waw_no_relief", 32'(stall_reason), 3);
    nxt();
    wb_valid = 0; mid();
    chk("waw_release", 32'(stall_decode), 0);
    nxt();
    idle(); mid();
    chk("waw_sc", 32'(stall_cycles), 5);
    chk("waw_out", 32'(outstanding), 1);
    nxt();
    ret(7); mid(); nxt();

    // structural priority and kill
    wr(10); mid(); nxt();
    idle(); dec_valid = 1; dec_use_rs2 = 1; dec_rs2 = 10;
    ext_stall = 1; mid();
    chk("struct_reason", 32'(stall_reason), 1);
    chk("struct_stall", 32'(stall_decode), 1);
    nxt();
    dec_kill = 1; mid();
    chk("kill_stall", 32'(stall_decode), 0);
    chk("kill_reason", 32'(stall_reason), 0);
    nxt();
    idle(); mid();
    chk("kill_out", 32'(outstanding), 1);
    chk("kill_sc", 32'(stall_cycles), 6);
    nxt();
    dec_valid = 1; dec_use_rs2 = 1; dec_rs2 = 10; mid();
    chk("rs2_raw", 32'(stall_reason), 2);
    nxt();
    idle(); ret(10); mid(); nxt();

    // spurious writeback and x0 handling
    idle(); ret(9); mid();
    chk("err_pre", 32'(sb_err), 0);
    nxt();
    idle(); mid(); chk("err_set", 32'(sb_err), 1); nxt();
    nxt(); nxt(); mid();
    chk("err_sticky", 32'(sb_err), 1);
    nxt();
    wr(0); dec_use_rs1 = 1; dec_rs1 = 0; mid();
    chk("x0_nostall", 32'(stall_decode), 0);
    nxt();
    idle(); mid(); chk("x0_out", 32'(outstanding), 0); nxt();

    // issue and writeback to the same register
    wr(3); ret(3); mid();
    chk("setwin_issue", 32'(stall_decode), 0);
    nxt();
    idle(); mid(); chk("setwin_out", 32'(outstanding), 1); nxt();
    rd1(3); mid(); chk("setwin_busy", 32'(stall_reason), 2); nxt();
    idle(); ret(3); mid(); nxt();

    // reset in flight
    for (int r = 1; r <= 3; r++) begin
      wr(5'(r)); mid(); nxt();
    end
    idle(); mid(); chk("fly_out", 32'(outstanding), 3); nxt();
    rd1(2); mid(); chk("fly_stall", 32'(stall_decode), 1); nxt();
    wr(4); reset = 1; mid(); nxt();
    reset = 0; rd1(2); mid();
    chk("fly_rst_out", 32'(outstanding), 0);
    chk("fly_rst_sc", 32'(stall_cycles), 0);
    chk("fly_rst_err", 32'(sb_err), 0);
    chk("fly_rst_issue", 32'(stall_decode), 0);
    nxt();

    // stall counter saturation
    idle(); ext_stall = 1;
    repeat (65536) nxt();
    mid(); chk("sat_a", 32'(stall_cycles), 32'hFFFF); nxt();
    mid(); chk("sat_b", 32'(stall_cycles), 32'hFFFF); nxt();
    idle(); nxt(); nxt();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
